// File: rtl/and_gate_if.sv
// Bundles the operand inputs and all results of and_gate; clk/rst remain
// plain ports on the module.
interface and_gate_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cnt_clr;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_rise;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output a, b, cnt_clr,
        input  f, f_q, f_rise, hi_cnt
    );

    modport slave (
        input  a, b, cnt_clr,
        output f, f_q, f_rise, hi_cnt
    );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND with a registered copy, a per-bit rising-edge pulse and a
// saturating count of cycles in which every result bit is high.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
    input logic       clk,
    input logic       rst,
    and_gate_if.slave bus
);
    logic [WIDTH-1:0] f_comb;
    logic [WIDTH-1:0] f_q_r;
    logic [WIDTH-1:0] f_rise_r;
    logic [CNT_W-1:0] hi_cnt_r;
    logic             all_hi;
    logic             cnt_full;

    // f stays purely combinational so it keeps tracking a & b through reset.
    always_comb begin
        f_comb   = bus.a & bus.b;
        all_hi   = &f_comb;
        cnt_full = &hi_cnt_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q_r    <= '0;
            f_rise_r <= '0;
            hi_cnt_r <= '0;
        end else begin
            f_q_r    <= f_comb;
            f_rise_r <= f_comb & ~f_q_r;
            // Clear wins over increment; the count holds once it saturates.
            if (bus.cnt_clr)
                hi_cnt_r <= '0;
            else if (all_hi && !cnt_full)
                hi_cnt_r <= hi_cnt_r + 1'b1;
        end
    end

    assign bus.f      = f_comb;
    assign bus.f_q    = f_q_r;
    assign bus.f_rise = f_rise_r;
    assign bus.hi_cnt = hi_cnt_r;
endmodule

// File: tb/tb_and_gate.sv
// Directed-vector bench for and_gate: default, 2-bit-counter and 4-bit-wide
// instances driven side by side from one linear stimulus sequence.
module tb_and_gate;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    and_gate_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
    and_gate_if #(.WIDTH(1), .CNT_W(2)) bus2 ();
    and_gate_if #(.WIDTH(4), .CNT_W(8)) bus3 ();

    and_gate #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    and_gate #(.WIDTH(1), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));
    and_gate #(.WIDTH(4), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.cnt_clr = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.cnt_clr = 1'b0;
        bus3.a = '0; bus3.b = '0; bus3.cnt_clr = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_f_q",     32'(bus1.f_q),    32'h0);
        chk("rst_f_rise",  32'(bus1.f_rise), 32'h0);
        chk("rst_hi_cnt",  32'(bus1.hi_cnt), 32'h0);
        chk("rst_hi_cnt2", 32'(bus2.hi_cnt), 32'h0);

        // Truth table, held in reset to also show f ignores rst
        bus1.a = 1'b0; bus1.b = 1'b0; #10 chk("tt_00", 32'(bus1.f), 32'h0);
        bus1.a = 1'b0; bus1.b = 1'b1; #10 chk("tt_01", 32'(bus1.f), 32'h0);
        bus1.a = 1'b1; bus1.b = 1'b0; #10 chk("tt_10", 32'(bus1.f), 32'h0);
        bus1.a = 1'b1; bus1.b = 1'b1; #10 chk("tt_11", 32'(bus1.f), 32'h1);
        chk("rst_hold_f_q",    32'(bus1.f_q),    32'h0);
        chk("rst_hold_hi_cnt", 32'(bus1.hi_cnt), 32'h0);

        bus2.a = 1'b1; bus2.b = 1'b1;
        bus3.a = 4'b1100; bus3.b = 4'b1010;
        #1 chk("w4_f", 32'(bus3.f), 32'h8);

        @(negedge clk);
        rst = 1'b0;

        tick();
        chk("c1_f_q",    32'(bus1.f_q),    32'h1);
        chk("c1_f_rise", 32'(bus1.f_rise), 32'h1);
        chk("c1_hi_cnt", 32'(bus1.hi_cnt), 32'h1);
        chk("sat_c1",    32'(bus2.hi_cnt), 32'h1);
        chk("w4_f_q",    32'(bus3.f_q),    32'h8);
        chk("w4_f_rise", 32'(bus3.f_rise), 32'h8);
        chk("w4_hi_c1",  32'(bus3.hi_cnt), 32'h0);
        tick();
        chk("c2_f_q",    32'(bus1.f_q),    32'h1);
        chk("c2_f_rise", 32'(bus1.f_rise), 32'h0);
        chk("c2_hi_cnt", 32'(bus1.hi_cnt), 32'h2);
        chk("sat_c2",    32'(bus2.hi_cnt), 32'h2);
        chk("w4_rise_c2", 32'(bus3.f_rise), 32'h0);
        tick();
        chk("c3_f_rise", 32'(bus1.f_rise), 32'h0);
        chk("c3_hi_cnt", 32'(bus1.hi_cnt), 32'h3);
        chk("sat_c3",    32'(bus2.hi_cnt), 32'h3);
        tick();
        chk("sat_c4",    32'(bus2.hi_cnt), 32'h3);
        tick();
        chk("sat_c5",    32'(bus2.hi_cnt), 32'h3);
        tick();
        chk("sat_c6",    32'(bus2.hi_cnt), 32'h3);
        chk("c6_hi_cnt", 32'(bus1.hi_cnt), 32'h6);
        chk("w4_hi_c6",  32'(bus3.hi_cnt), 32'h0);

        // Clear with f high at the same edge
        @(negedge clk);
        bus1.cnt_clr = 1'b1;
        tick();
        chk("clr_prio", 32'(bus1.hi_cnt), 32'h0);
        @(negedge clk);
        bus1.cnt_clr = 1'b0;
        repeat (3) tick();
        chk("recount3", 32'(bus1.hi_cnt), 32'h3);

        // Drop f for one cycle, then raise it again
        @(negedge clk);
        bus1.a = 1'b0;
        tick();
        chk("drop_f_q",    32'(bus1.f_q),    32'h0);
        chk("drop_f_rise", 32'(bus1.f_rise), 32'h0);
        chk("drop_hi_cnt", 32'(bus1.hi_cnt), 32'h3);
        @(negedge clk);
        bus1.a = 1'b1;
        tick();
        chk("rerise_f_rise", 32'(bus1.f_rise), 32'h1);
        chk("rerise_hi_cnt", 32'(bus1.hi_cnt), 32'h4);
        tick();
        chk("hold_f_rise", 32'(bus1.f_rise), 32'h0);
        chk("cnt5",        32'(bus1.hi_cnt), 32'h5);

        // Asynchronous reset between edges, mid-count
        #2 rst = 1'b1;
        #1;
        chk("arst_hi_cnt", 32'(bus1.hi_cnt), 32'h0);
        chk("arst_f_q",    32'(bus1.f_q),    32'h0);
        chk("arst_f_rise", 32'(bus1.f_rise), 32'h0);
        chk("arst_f",      32'(bus1.f),      32'h1);
        bus1.a = 1'b0;
        #1 chk("arst_f_track", 32'(bus1.f), 32'h0);
        @(negedge clk);
        bus1.a = 1'b1;
        rst = 1'b0;
        tick();
        chk("post_rst_hi_cnt", 32'(bus1.hi_cnt), 32'h1);
        chk("post_rst_f_rise", 32'(bus1.f_rise), 32'h1);
        chk("post_rst_f_q",    32'(bus1.f_q),    32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
